// File: rtl/dmem_port_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_port_arbiter_pkg
//   Shared types and helpers for the MEM-stage data memory port arbiter.
//   Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
package dmem_port_arbiter_pkg;

  // Default data memory size in bytes; legal word addresses are 0..DMEM_BYTES-4.
  localparam int DMEM_BYTES = 32;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    SERVE_B = 1'b1
  } arb_state_t;

  // A word access is legal when word aligned and entirely inside the memory.
  function automatic logic addr_legal(input logic [31:0] addr, input int unsigned mem_bytes);
    return (addr[1:0] == 2'b00) && (addr <= (mem_bytes - 32'd4));
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_port_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_port_arbiter_if
//   Single data memory port: command from the arbiter, combinational read
//   data back from the memory.
//   Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
interface dmem_port_arbiter_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/dmem_port_arbiter_sat_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sat_counter
//   Up counter that sticks at all-ones instead of wrapping.
//   Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             inc,
  output logic [CNT_W-1:0]      count
);

  localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Count enabled cycles, holding once every bit is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + C_ONE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_port_arbiter
//   Sequences lane A / lane B loads and stores onto the single data memory
//   port. A lone request passes straight through; a same-cycle pair is served
//   A then B over two cycles with a one-cycle pipeline stall.
//   Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module dmem_port_arbiter #(
  parameter int DMEM_BYTES = dmem_port_arbiter_pkg::DMEM_BYTES,
  parameter int CNT_W      = 16
) (
  input  wire logic               clk,
  input  wire logic               btnc_i,
  input  wire logic               a_read_i,
  input  wire logic               a_write_i,
  input  wire logic [31:0]        a_addr_i,
  input  wire logic [31:0]        a_wdata_i,
  input  wire logic               b_read_i,
  input  wire logic               b_write_i,
  input  wire logic [31:0]        b_addr_i,
  input  wire logic [31:0]        b_wdata_i,
  dmem_port_arbiter_if.master     mem,
  output logic [31:0]             a_rdata_o,
  output logic [31:0]             b_rdata_o,
  output logic                    stall_o,
  output logic                    misalign_o,
  output logic [CNT_W-1:0]        conflict_cnt_o
);

  import dmem_port_arbiter_pkg::*;

  arb_state_t  state, state_nx;
  logic [31:0] a_hold, a_hold_nx;
  logic        a_ok, b_ok;
  logic        a_req, b_req;
  logic        a_rd, b_rd;
  logic        bad_access;
  logic        port_rd, port_wr;
  logic        stall_c;
  logic        cnt_inc;

  // Lane qualification: write wins over read, illegal addresses drop out.
  always_comb begin
    a_ok       = addr_legal(a_addr_i, DMEM_BYTES);
    b_ok       = addr_legal(b_addr_i, DMEM_BYTES);
    a_rd       = a_read_i & ~a_write_i;
    b_rd       = b_read_i & ~b_write_i;
    a_req      = (a_read_i | a_write_i) & a_ok;
    b_req      = (b_read_i | b_write_i) & b_ok;
    bad_access = ((a_read_i | a_write_i) & ~a_ok) | ((b_read_i | b_write_i) & ~b_ok);
  end

  // Next state, port steering and per-lane read data.
  always_comb begin
    state_nx      = state;
    a_hold_nx     = a_hold;
    port_rd       = 1'b0;
    port_wr       = 1'b0;
    mem.mem_addr  = 32'h0;
    mem.mem_wdata = 32'h0;
    a_rdata_o     = 32'h0;
    b_rdata_o     = 32'h0;
    stall_c       = 1'b0;
    cnt_inc       = 1'b0;
    case (state)
      IDLE: begin
        if (a_req) begin
          port_rd       = a_rd;
          port_wr       = a_write_i;
          mem.mem_addr  = a_addr_i;
          mem.mem_wdata = a_wdata_i;
          if (b_req) begin
            // A goes first; its load result waits in a_hold for the B cycle.
            a_hold_nx = a_rd ? mem.mem_rdata : 32'h0;
            stall_c   = 1'b1;
            cnt_inc   = 1'b1;
            state_nx  = SERVE_B;
          end else begin
            a_rdata_o = a_rd ? mem.mem_rdata : 32'h0;
          end
        end else if (b_req) begin
          port_rd       = b_rd;
          port_wr       = b_write_i;
          mem.mem_addr  = b_addr_i;
          mem.mem_wdata = b_wdata_i;
          b_rdata_o     = b_rd ? mem.mem_rdata : 32'h0;
        end
      end
      SERVE_B: begin
        // Lane inputs are frozen by the stall, so B is taken from the live ports.
        port_rd       = b_rd;
        port_wr       = b_write_i;
        mem.mem_addr  = b_addr_i;
        mem.mem_wdata = b_wdata_i;
        a_rdata_o     = a_hold;
        b_rdata_o     = mem.mem_rdata;
        state_nx      = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Reset low keeps the port quiet so switch loading of memory is untouched.
  always_comb begin
    mem.mem_read  = port_rd & btnc_i;
    mem.mem_write = port_wr & btnc_i;
    stall_o       = stall_c & btnc_i;
  end

  // State, held A load data and sticky misalignment flag.
  always_ff @(posedge clk or negedge btnc_i) begin
    if (!btnc_i) begin
      state      <= IDLE;
      a_hold     <= 32'h0;
      misalign_o <= 1'b0;
    end else begin
      state  <= state_nx;
      a_hold <= a_hold_nx;
      if (bad_access) begin
        misalign_o <= 1'b1;
      end
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_conflict_cnt (
    .clk   (clk),
    .rst_n (btnc_i),
    .inc   (cnt_inc),
    .count (conflict_cnt_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dmem_port_arbiter
//   Directed stimulus with a behavioural reference model of the arbiter and a
//   small data memory attached to the port.
//   Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_dmem_port_arbiter;

  localparam int DB    = 32;
  localparam int CNT_W = 16;

  logic        clk = 1'b0;
  logic        btnc = 1'b0;
  logic        a_read = 0, a_write = 0, b_read = 0, b_write = 0;
  logic [31:0] a_addr = 0, a_wdata = 0, b_addr = 0, b_wdata = 0;
  logic [31:0] a_rdata, b_rdata;
  logic        stall, misalign;
  logic [CNT_W-1:0] cnt;
  logic        sat_inc = 1'b0;
  logic [15:0] sat_cnt;

  int checks = 0;
  int errors = 0;

  dmem_port_arbiter_if ifc ();

  dmem_port_arbiter #(.DMEM_BYTES(DB), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .btnc_i         (btnc),
    .a_read_i       (a_read),
    .a_write_i      (a_write),
    .a_addr_i       (a_addr),
    .a_wdata_i      (a_wdata),
    .b_read_i       (b_read),
    .b_write_i      (b_write),
    .b_addr_i       (b_addr),
    .b_wdata_i      (b_wdata),
    .mem            (ifc),
    .a_rdata_o      (a_rdata),
    .b_rdata_o      (b_rdata),
    .stall_o        (stall),
    .misalign_o     (misalign),
    .conflict_cnt_o (cnt)
  );

  sat_counter #(.CNT_W(16)) u_sat (
    .clk   (clk),
    .rst_n (btnc),
    .inc   (sat_inc),
    .count (sat_cnt)
  );

  always #5 clk = ~clk;

  // Data memory on the port: combinational read, write on the rising edge.
  logic [31:0] tb_mem [8];
  assign ifc.mem_rdata = ifc.mem_read ? tb_mem[ifc.mem_addr[4:2]] : 32'h0;
  always @(posedge clk) if (ifc.mem_write) tb_mem[ifc.mem_addr[4:2]] <= ifc.mem_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_mem [8];
  bit          m_dual = 0;
  logic [31:0] m_hold = 0;
  bit          m_mis = 0;
  int          m_cnt = 0;

  function automatic bit legal(input logic [31:0] ad);
    return (ad % 4 == 0) && (ad <= DB - 4);
  endfunction

  initial begin : model_check
    bit a_go, b_go, bad;
    logic e_rd, e_wr, e_st;
    logic [31:0] e_addr, e_wd, e_ard, e_brd;
    forever begin
      @(negedge clk); #3;
      if (!btnc) begin
        chk("rst_mem_read", {31'b0, ifc.mem_read}, 0);
        chk("rst_mem_write", {31'b0, ifc.mem_write}, 0);
        chk("rst_stall", {31'b0, stall}, 0);
        chk("rst_misalign", {31'b0, misalign}, 0);
        chk("rst_cnt", {16'b0, cnt}, 0);
        m_dual = 0; m_hold = 0; m_mis = 0; m_cnt = 0;
      end else begin
        a_go = (a_read || a_write) && legal(a_addr);
        b_go = (b_read || b_write) && legal(b_addr);
        bad  = ((a_read || a_write) && !legal(a_addr)) || ((b_read || b_write) && !legal(b_addr));
        e_rd = 0; e_wr = 0; e_st = 0; e_addr = 0; e_wd = 0; e_ard = 0; e_brd = 0;
        if (m_dual) begin
          // Second half of a pair: B on the port, A's result from the hold.
          e_rd = b_read && !b_write; e_wr = b_write; e_addr = b_addr; e_wd = b_wdata;
          e_ard = m_hold;
          e_brd = e_rd ? m_mem[b_addr / 4] : 32'h0;
        end else if (a_go && b_go) begin
          e_rd = a_read && !a_write; e_wr = a_write; e_addr = a_addr; e_wd = a_wdata;
          e_st = 1;
        end else if (a_go) begin
          e_rd = a_read && !a_write; e_wr = a_write; e_addr = a_addr; e_wd = a_wdata;
          e_ard = e_rd ? m_mem[a_addr / 4] : 32'h0;
        end else if (b_go) begin
          e_rd = b_read && !b_write; e_wr = b_write; e_addr = b_addr; e_wd = b_wdata;
          e_brd = e_rd ? m_mem[b_addr / 4] : 32'h0;
        end
        chk("mem_read", {31'b0, ifc.mem_read}, {31'b0, e_rd});
        chk("mem_write", {31'b0, ifc.mem_write}, {31'b0, e_wr});
        chk("mem_addr", ifc.mem_addr, e_addr);
        chk("mem_wdata", ifc.mem_wdata, e_wd);
        chk("stall", {31'b0, stall}, {31'b0, e_st});
        chk("a_rdata", a_rdata, e_ard);
        chk("b_rdata", b_rdata, e_brd);
        chk("misalign", {31'b0, misalign}, {31'b0, m_mis});
        chk("conflict_cnt", {16'b0, cnt}, m_cnt);
        // Effects of the coming rising edge.
        if (e_st) begin
          m_hold = e_rd ? m_mem[a_addr / 4] : 32'h0;
          if (m_cnt < 65535) m_cnt++;
        end
        if (e_wr) m_mem[e_addr / 4] = e_wd;
        if (bad) m_mis = 1;
        m_dual = e_st;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic lanes(input logic ar, input logic aw, input logic [31:0] aa, input logic [31:0] ad,
                       input logic br, input logic bw, input logic [31:0] ba, input logic [31:0] bd);
    a_read = ar; a_write = aw; a_addr = aa; a_wdata = ad;
    b_read = br; b_write = bw; b_addr = ba; b_wdata = bd;
  endtask

  task automatic idle();
    lanes(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : stim
    logic [3:0] st_pat;
    // Reset
    @(negedge clk); #4;
    chk("reset_stall", {31'b0, stall}, 0);
    chk("reset_cnt", {16'b0, cnt}, 0);
    @(negedge clk);
    btnc = 1;

    // Lone A store then load of the same word
    lanes(0, 1, 8, 32'h7, 0, 0, 0, 0); #4;
    chk("a_store_write", {31'b0, ifc.mem_write}, 1);
    chk("a_store_addr", ifc.mem_addr, 8);
    chk("a_store_stall", {31'b0, stall}, 0);
    @(negedge clk);
    lanes(1, 0, 8, 0, 0, 0, 0, 0); #4;
    chk("a_load_8", a_rdata, 32'h7);
    @(negedge clk);

    // Preload words used below via lone stores
    lanes(0, 1, 0, 32'h5, 0, 0, 0, 0);    @(negedge clk);
    lanes(0, 0, 0, 0, 0, 1, 12, 32'h9);   @(negedge clk);
    lanes(0, 1, 20, 32'h2020, 0, 0, 0, 0); @(negedge clk);

    // A store / B load same word: B sees A's data
    lanes(0, 1, 4, 32'h11, 1, 0, 4, 0); #4;
    chk("pair_c0_stall", {31'b0, stall}, 1);
    chk("pair_c0_addr", ifc.mem_addr, 4);
    @(negedge clk); #4;
    chk("pair_c1_stall", {31'b0, stall}, 0);
    chk("pair_c1_read", {31'b0, ifc.mem_read}, 1);
    chk("pair_c1_b_rdata", b_rdata, 32'h11);
    @(negedge clk);
    idle(); #4;
    chk("pair_cnt", {16'b0, cnt}, 1);
    @(negedge clk);

    // Both lanes load
    lanes(1, 0, 0, 0, 1, 0, 12, 0);
    @(negedge clk); #4;
    chk("dual_load_a", a_rdata, 32'h5);
    chk("dual_load_b", b_rdata, 32'h9);
    @(negedge clk);

    // Both lanes store the same word: B wins
    lanes(0, 1, 16, 32'hAA, 0, 1, 16, 32'hBB);
    repeat (2) @(negedge clk);
    idle(); #4;
    chk("dual_store_mem16", tb_mem[4], 32'hBB);
    @(negedge clk);

    // Misaligned A with legal B: B alone, flag from the next edge
    lanes(1, 0, 6, 0, 1, 0, 20, 0); #4;
    chk("mis_stall", {31'b0, stall}, 0);
    chk("mis_port_addr", ifc.mem_addr, 20);
    chk("mis_a_rdata", a_rdata, 0);
    chk("mis_b_rdata", b_rdata, 32'h2020);
    chk("mis_flag_before", {31'b0, misalign}, 0);
    @(negedge clk);
    idle(); #4;
    chk("mis_flag_after", {31'b0, misalign}, 1);
    @(negedge clk);

    // Back-to-back pairs: stall 1,0,1,0
    st_pat = 0;
    lanes(0, 1, 24, 32'h24, 0, 1, 28, 32'h28);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) lanes(1, 0, 24, 0, 1, 0, 28, 0);
      #4; st_pat = {st_pat[2:0], stall};
      @(negedge clk);
    end
    chk("b2b_stall_pattern", {28'b0, st_pat}, 32'hA);
    idle(); @(negedge clk);

    // Reset pulse during the B half aborts B's store
    lanes(0, 1, 0, 32'h33, 0, 1, 0, 32'h44);
    @(negedge clk);
    btnc = 0; #4;
    chk("rstpulse_write", {31'b0, ifc.mem_write}, 0);
    chk("rstpulse_stall", {31'b0, stall}, 0);
    chk("rstpulse_cnt", {16'b0, cnt}, 0);
    @(negedge clk);
    btnc = 1; idle(); #4;
    chk("after_rst_stall", {31'b0, stall}, 0);
    @(negedge clk);
    lanes(0, 0, 0, 0, 1, 0, 0, 0); #4;
    chk("after_rst_b_load", b_rdata, 32'h33);
    chk("after_rst_single", {31'b0, stall}, 0);
    @(negedge clk);
    idle();

    // Counter saturation over 2^16 + a few increments
    #4;
    chk("sat_start", {16'b0, sat_cnt}, 0);
    @(negedge clk);
    sat_inc = 1;
    repeat (65536 + 4) @(negedge clk);
    sat_inc = 0; #4;
    chk("sat_hold", {16'b0, sat_cnt}, 32'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
`default_nettype wire
